// File: rtl/fir_decim_fifo.sv
// fir_decim_fifo: drops the FIR fill transient after reset, boxcar-averages
// groups of DECIM samples with round-half-up, and queues the averages in a
// small circular FIFO behind a valid/ready handshake.
module fir_decim_fifo #(
  parameter int DECIM      = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int WARMUP     = 23
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic signed [15:0]            y_in,
  output logic signed [15:0]            m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow
);

  localparam int LD = $clog2(DECIM);
  localparam int AW = 16 + LD;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int WW = $clog2(WARMUP + 1) + 1;

  typedef enum logic {WARM, RUN} state_t;

  state_t            state_reg, state_next;
  logic [WW-1:0]     warm_cnt_reg, warm_cnt_next;
  logic [LD-1:0]     phase_reg;
  logic signed [AW-1:0] acc_reg;

  logic signed [15:0] mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_reg, rd_ptr_reg;
  logic [PW:0]       count_reg;
  logic              overflow_reg;

  // Sign-extended operands; one spare bit keeps the rounding sum exact.
  logic signed [AW:0] y_ext, acc_ext, round_sum;
  logic signed [15:0] result;
  logic               last_phase, push, pop, full, wr_en;
  logic               unused_bits;

  assign y_ext       = {{(AW + 1 - 16){y_in[15]}}, y_in};
  assign acc_ext     = {acc_reg[AW-1], acc_reg};
  assign round_sum   = acc_ext + y_ext + (AW + 1)'(DECIM / 2);
  assign result      = round_sum[LD+15:LD];
  assign unused_bits = ^{round_sum[AW], round_sum[LD-1:0]};

  assign last_phase = (phase_reg == LD'(DECIM - 1));
  assign push       = (state_reg == RUN) && last_phase;
  assign full       = (count_reg == (PW + 1)'(FIFO_DEPTH));
  assign pop        = m_valid && m_ready;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign wr_en      = push && (!full || pop);

  assign m_valid  = (count_reg != '0);
  assign level    = count_reg;
  assign overflow = overflow_reg;
  assign m_data   = m_valid ? mem[rd_ptr_reg] : '0;

  // State and warm-up counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= (WARMUP == 0) ? RUN : WARM;
      warm_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      warm_cnt_reg <= warm_cnt_next;
    end
  end

  // Warm-up sequencing: count discarded samples, then stay in RUN until reset.
  always_comb begin
    state_next    = state_reg;
    warm_cnt_next = warm_cnt_reg;
    if (state_reg == WARM) begin
      warm_cnt_next = warm_cnt_reg + WW'(1);
      if (warm_cnt_reg == WW'(WARMUP - 1)) state_next = RUN;
    end
  end

  // Phase counter and boxcar accumulator; phase 0 restarts the sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_reg <= '0;
      acc_reg   <= '0;
    end else if (state_reg == RUN) begin
      phase_reg <= phase_reg + LD'(1);
      acc_reg   <= (phase_reg == '0) ? y_ext[AW-1:0] : acc_reg + y_ext[AW-1:0];
    end
  end

  // FIFO storage write; left unreset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem[wr_ptr_reg] <= result;
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)   rd_ptr_reg <= rd_ptr_reg + PW'(1);
      case ({wr_en, pop})
        2'b10:   count_reg <= count_reg + (PW + 1)'(1);
        2'b01:   count_reg <= count_reg - (PW + 1)'(1);
        default: count_reg <= count_reg;
      endcase
      if (push && full && !pop) overflow_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fir_decim_fifo.sv
// Testbench for fir_decim_fifo: random and directed stimulus compared every
// cycle against a queue-based model of warm-up, group averaging and FIFO.
module tb_fir_decim_fifo;

  localparam int DECIM  = 4;
  localparam int DEPTH  = 8;
  localparam int WARMUP = 23;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic signed [15:0] y_in = '0;
  logic signed [15:0] m_data;
  logic               m_valid;
  logic               m_ready = 1'b0;
  logic [3:0]         level;
  logic               overflow;

  always #5 clk = ~clk;

  fir_decim_fifo #(.DECIM(DECIM), .FIFO_DEPTH(DEPTH), .WARMUP(WARMUP)) dut (
    .clk(clk), .rst(rst), .y_in(y_in), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .level(level), .overflow(overflow)
  );

  int errors = 0;
  int checks = 0;
  int q[$];
  int grp[$];
  int edge_cnt = 0;
  bit ovf = 1'b0;
  int max_level = 0;

  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: edges since reset release, group list, plain-arithmetic average.
  task automatic model_edge(input int y, input bit r, input bit rs);
    bit pop_now, push_now;
    int sum, res;
    if (rs) begin
      q.delete(); grp.delete(); edge_cnt = 0; ovf = 1'b0;
      return;
    end
    pop_now  = (q.size() > 0) && r;
    push_now = 1'b0;
    res      = 0;
    edge_cnt++;
    if (edge_cnt > WARMUP) begin
      grp.push_back(y);
      if (grp.size() == DECIM) begin
        sum = 0;
        foreach (grp[i]) sum += grp[i];
        res = (sum + DECIM / 2) >>> $clog2(DECIM);
        grp.delete();
        push_now = 1'b1;
      end
    end
    if (pop_now) void'(q.pop_front());
    if (push_now) begin
      if (q.size() < DEPTH) q.push_back(res);
      else ovf = 1'b1;
    end
  endtask

  task automatic compare_all();
    check("level", level, q.size());
    check("m_valid", m_valid, (q.size() != 0));
    check("m_data", $signed(m_data), (q.size() != 0) ? q[0] : 0);
    check("overflow", overflow, ovf);
    if (int'(level) > max_level) max_level = int'(level);
  endtask

  task automatic step(input int y, input bit r);
    y_in    = 16'(y);
    m_ready = r;
    if (m_valid && r && !rst) $display("pop data=%0d level=%0d", $signed(m_data), level);
    @(posedge clk);
    model_edge(y, r, rst);
    #1;
    compare_all();
  endtask

  function automatic int rnd16();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    step(0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic warm(input bit r);
    for (int i = 0; i < WARMUP; i++) step(rnd16(), r);
  endtask

  int rvals[16] = '{1, 2, 2, 2, -1, -2, -2, -2,
                    32767, 32767, 32767, 32767, -32768, -32768, -32768, -32768};
  int rexp[4]   = '{2, -2, 32767, -32768};
  int n;

  initial begin
    // 1: reset state and warm-up with glitching input
    step(0, 1'b0);
    step(0, 1'b0);
    check("rst_valid", m_valid, 0);
    check("rst_level", level, 0);
    check("rst_ovf", overflow, 0);
    check("rst_data", $signed(m_data), 0);
    rst = 1'b0;
    warm(1'b1);
    for (int i = 0; i < 3; i++) step(1000, 1'b1);
    check("warm_no_valid", m_valid, 0);
    step(1000, 1'b1);
    check("warm_first_valid", m_valid, 1);
    check("warm_first_data", $signed(m_data), 1000);
    for (int i = 0; i < 24; i++) step(1000, 1'b1);

    // 2: rounding at small values and full scale
    for (int g = 0; g < 4; g++) begin
      for (int k = 0; k < 4; k++) step(rvals[g*4+k], 1'b1);
      check("round", $signed(m_data), rexp[g]);
    end

    // 3: backpressure until overflow, then drain in order
    do_reset();
    warm(1'b0);
    for (int g = 1; g <= 10; g++)
      for (int k = 0; k < 4; k++) step(g, 1'b0);
    check("bp_level", level, 8);
    check("bp_ovf", overflow, 1);
    for (int i = 1; i <= 8; i++) begin
      check("drain_head", $signed(m_data), i);
      step(0, 1'b1);
    end
    for (int i = 0; i < 8; i++) step(0, 1'b1);
    check("drain_ovf_sticky", overflow, 1);

    // 4: push and pop together while full
    do_reset();
    warm(1'b0);
    for (int i = 0; i < 32; i++) step(rnd16(), 1'b0);
    check("full_level", level, 8);
    for (int i = 0; i < 3; i++) step(rnd16(), 1'b0);
    step(rnd16(), 1'b1);
    check("full_pp_level", level, 8);
    check("full_pp_ovf", overflow, 0);
    for (int i = 0; i < 40; i++) step(rnd16(), 1'b1);

    // 5: pointer wrap with toggling ready, then random ready
    do_reset();
    warm(1'b1);
    max_level = 0;
    for (int i = 0; i < 400; i++) step(rnd16(), (i % 2) == 0);
    check("wrap_ovf", overflow, 0);
    check("wrap_max_level_ok", (max_level <= DEPTH), 1);
    for (int i = 0; i < 400; i++) step(rnd16(), 1'($urandom_range(0, 1)));

    // 6: reset mid-phase with five entries queued
    do_reset();
    warm(1'b0);
    for (int i = 0; i < 22; i++) step(rnd16(), 1'b0);
    check("mid_level", level, 5);
    rst = 1'b1;
    step(rnd16(), 1'b1);
    rst = 1'b0;
    check("mid_rst_valid", m_valid, 0);
    check("mid_rst_level", level, 0);
    check("mid_rst_ovf", overflow, 0);
    n = 0;
    while (!m_valid && n < 40) begin
      step(rnd16(), 1'b0);
      n++;
    end
    check("mid_rst_push_edge", n, WARMUP + DECIM);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
